// File: rtl/axi_write_arbiter.sv
// Two-master to one-slave AXI3 write arbiter, round-robin, one whole transaction at a time.
// Latency: one cycle of arbitration in IDLE, then AW/W/B pass combinationally through the grant mux.
// Backpressure: READYs follow the slave for the granted master only; all else sees READY=0.
module axi_write_arbiter #(
  parameter int buswidth = 32
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [53:0]                         M0_AWINFO,
  input  logic                                M0_AWVALID,
  output logic                                M0_AWREADY,
  input  logic [4+buswidth+buswidth/8+1-1:0]  M0_W,
  input  logic                                M0_WVALID,
  output logic                                M0_WREADY,
  output logic [3:0]                          M0_BID,
  output logic [1:0]                          M0_BRESP,
  output logic                                M0_BVALID,
  input  logic                                M0_BREADY,
  input  logic [53:0]                         M1_AWINFO,
  input  logic                                M1_AWVALID,
  output logic                                M1_AWREADY,
  input  logic [4+buswidth+buswidth/8+1-1:0]  M1_W,
  input  logic                                M1_WVALID,
  output logic                                M1_WREADY,
  output logic [3:0]                          M1_BID,
  output logic [1:0]                          M1_BRESP,
  output logic                                M1_BVALID,
  input  logic                                M1_BREADY,
  output logic [53:0]                         S_AWINFO,
  output logic                                S_AWVALID,
  input  logic                                S_AWREADY,
  output logic [4+buswidth+buswidth/8+1-1:0]  S_W,
  output logic                                S_WVALID,
  input  logic                                S_WREADY,
  input  logic [3:0]                          S_BID,
  input  logic [1:0]                          S_BRESP,
  input  logic                                S_BVALID,
  output logic                                S_BREADY,
  output logic                                grant,
  output logic                                busy,
  output logic [1:0]                          err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state, state_nxt;
  logic       ptr;
  logic [3:0] cnt;
  logic [3:0] len;
  logic [3:0] id;
  logic       aw_hs, w_hs, b_hs, w_last, any_req;

  assign any_req = M0_AWVALID || M1_AWVALID;
  assign aw_hs   = S_AWVALID && S_AWREADY;
  assign w_hs    = S_WVALID && S_WREADY;
  assign b_hs    = S_BVALID && S_BREADY;
  assign w_last  = S_W[0];

  // state register
  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: one transaction walks IDLE -> ADDR -> DATA -> RESP -> IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_req)         state_nxt = ADDR;
      ADDR: if (aw_hs)           state_nxt = DATA;
      DATA: if (w_hs && w_last)  state_nxt = RESP;
      RESP: if (b_hs)            state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // grant, round-robin pointer, latched AW fields, beat counter and sticky errors
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      grant <= 1'b0;
      ptr   <= 1'b0;
      cnt   <= 4'd0;
      len   <= 4'd0;
      id    <= 4'd0;
      err   <= 2'b00;
    end else begin
      case (state)
        IDLE: if (any_req) grant <= (M0_AWVALID && M1_AWVALID) ? ptr : M1_AWVALID;
        ADDR: if (aw_hs) begin
          len <= S_AWINFO[17:14];
          id  <= S_AWINFO[53:50];
          cnt <= 4'd0;
        end
        DATA: if (w_hs) begin
          // cnt is the index of the beat being accepted; the last one must equal AWLEN
          if (cnt != 4'hF) cnt <= cnt + 4'd1;
          if (w_last ? (cnt != len) : (cnt == len)) err[0] <= 1'b1;
        end
        RESP: if (b_hs) begin
          if (S_BID != id) err[1] <= 1'b1;
          ptr <= ~grant;
        end
        default: ;
      endcase
    end
  end

  // channel muxes: only the channel owned by the current state is connected to the winner
  always_comb begin
    M0_AWREADY = 1'b0;
    M1_AWREADY = 1'b0;
    M0_WREADY  = 1'b0;
    M1_WREADY  = 1'b0;
    M0_BID     = 4'd0;
    M0_BRESP   = 2'd0;
    M0_BVALID  = 1'b0;
    M1_BID     = 4'd0;
    M1_BRESP   = 2'd0;
    M1_BVALID  = 1'b0;
    S_AWINFO   = '0;
    S_AWVALID  = 1'b0;
    S_W        = '0;
    S_WVALID   = 1'b0;
    S_BREADY   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      ADDR: begin
        S_AWINFO  = grant ? M1_AWINFO  : M0_AWINFO;
        S_AWVALID = grant ? M1_AWVALID : M0_AWVALID;
        if (grant) M1_AWREADY = S_AWREADY;
        else       M0_AWREADY = S_AWREADY;
      end
      DATA: begin
        S_W      = grant ? M1_W      : M0_W;
        S_WVALID = grant ? M1_WVALID : M0_WVALID;
        if (grant) M1_WREADY = S_WREADY;
        else       M0_WREADY = S_WREADY;
      end
      RESP: begin
        S_BREADY = grant ? M1_BREADY : M0_BREADY;
        if (grant) begin
          M1_BVALID = S_BVALID;
          M1_BID    = S_BID;
          M1_BRESP  = S_BRESP;
        end else begin
          M0_BVALID = S_BVALID;
          M0_BID    = S_BID;
          M0_BRESP  = S_BRESP;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: the bench plays both masters and the slave.
// Inputs are driven on the falling edge, outputs sampled #1 later.
// Every wait on the DUT is bounded and a timeout counts as a failed check.
module tb_axi_write_arbiter;
  localparam int bw = 32;
  localparam int ww = 4 + bw + bw/8 + 1;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [53:0]   M0_AWINFO, M1_AWINFO, S_AWINFO;
  logic          M0_AWVALID, M0_AWREADY, M1_AWVALID, M1_AWREADY, S_AWVALID, S_AWREADY;
  logic [ww-1:0] M0_W, M1_W, S_W;
  logic          M0_WVALID, M0_WREADY, M1_WVALID, M1_WREADY, S_WVALID, S_WREADY;
  logic [3:0]    M0_BID, M1_BID, S_BID;
  logic [1:0]    M0_BRESP, M1_BRESP, S_BRESP;
  logic          M0_BVALID, M0_BREADY, M1_BVALID, M1_BREADY, S_BVALID, S_BREADY;
  logic          grant, busy;
  logic [1:0]    err;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.buswidth(bw)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .M0_AWINFO(M0_AWINFO), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
    .M0_W(M0_W), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
    .M0_BID(M0_BID), .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
    .M1_AWINFO(M1_AWINFO), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
    .M1_W(M1_W), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
    .M1_BID(M1_BID), .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
    .S_AWINFO(S_AWINFO), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_W(S_W), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .grant(grant), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [53:0] mkinfo(input logic [3:0] id, input logic [31:0] addr,
                                         input logic [3:0] len);
    return {id, addr, len, 3'd2, 2'd1, 2'd0, 4'd3, 3'd0};
  endfunction

  function automatic logic awrdy(input int m);
    return (m == 1) ? M1_AWREADY : M0_AWREADY;
  endfunction
  function automatic logic wrdy(input int m);
    return (m == 1) ? M1_WREADY : M0_WREADY;
  endfunction
  function automatic logic bvld(input int m);
    return (m == 1) ? M1_BVALID : M0_BVALID;
  endfunction

  task automatic set_aw(input int m, input logic v, input logic [53:0] info);
    if (m == 1) begin M1_AWVALID = v; M1_AWINFO = info; end
    else        begin M0_AWVALID = v; M0_AWINFO = info; end
  endtask
  task automatic set_w(input int m, input logic v, input logic [ww-1:0] w);
    if (m == 1) begin M1_WVALID = v; M1_W = w; end
    else        begin M0_WVALID = v; M0_W = w; end
  endtask
  task automatic set_br(input int m, input logic v);
    if (m == 1) M1_BREADY = v;
    else        M0_BREADY = v;
  endtask

  task automatic do_reset();
    M0_AWINFO = '0; M0_AWVALID = 0; M0_W = '0; M0_WVALID = 0; M0_BREADY = 0;
    M1_AWINFO = '0; M1_AWVALID = 0; M1_W = '0; M1_WVALID = 0; M1_BREADY = 0;
    S_AWREADY = 0; S_WREADY = 0; S_BID = '0; S_BRESP = '0; S_BVALID = 0;
    ARESETn = 0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1;
  endtask

  // One write from master m. keep: leave AWVALID up afterwards. abort: stop after
  // nbeats non-last beats without a response.
  task automatic run_txn(input int m, input logic [3:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input int nbeats, input logic [31:0] dbase,
                         input logic [3:0] bid, input logic [1:0] bresp, input bit toggle,
                         input bit keep, input bit abort, input logic [1:0] exp_err);
    logic [53:0]   info;
    logic [ww-1:0] w;
    int            n, b, cyc;
    int            o;
    o    = 1 - m;
    info = mkinfo(id, addr, len);
    set_aw(m, 1'b1, info);
    n = 0;
    do begin
      @(negedge ACLK); #1; n++;
    end while (!busy && n < 20);
    chk("aw_wait_busy", 64'(busy), 64'(1));
    chk("grant", 64'(grant), 64'(m));
    chk("s_awvalid", 64'(S_AWVALID), 64'(1));
    chk("s_awinfo", 64'(S_AWINFO), 64'(info));
    S_AWREADY = 1'b1; #1;
    chk("own_awready", 64'(awrdy(m)), 64'(1));
    chk("other_awready", 64'(awrdy(o)), 64'(0));
    @(negedge ACLK);
    S_AWREADY = 1'b0;
    if (!keep) set_aw(m, 1'b0, '0);
    b = 0; cyc = 0;
    while (b < nbeats && cyc < 200) begin
      w = {id, 32'(dbase + 32'(b)), 4'hF, (b == nbeats - 1) && !abort};
      set_w(m, 1'b1, w);
      S_WREADY = toggle ? cyc[0] : 1'b1;
      #1;
      chk("other_wready", 64'(wrdy(o)), 64'(0));
      chk("s_awvalid_in_data", 64'(S_AWVALID), 64'(0));
      if (S_WVALID && S_WREADY) begin
        chk("s_w", 64'(S_W), 64'(w));
        chk("own_wready", 64'(wrdy(m)), 64'(1));
        b++;
      end
      @(negedge ACLK);
      cyc++;
    end
    chk("beats", 64'(b), 64'(nbeats));
    set_w(m, 1'b0, '0);
    S_WREADY = 1'b0;
    if (abort) return;
    #1;
    chk("s_wvalid_after_last", 64'(S_WVALID), 64'(0));
    S_BVALID = 1'b1; S_BID = bid; S_BRESP = bresp;
    set_br(m, 1'b1);
    #1;
    chk("own_bvalid", 64'(bvld(m)), 64'(1));
    chk("other_bvalid", 64'(bvld(o)), 64'(0));
    chk("own_bid", 64'((m == 1) ? M1_BID : M0_BID), 64'(bid));
    chk("own_bresp", 64'((m == 1) ? M1_BRESP : M0_BRESP), 64'(bresp));
    chk("s_bready", 64'(S_BREADY), 64'(1));
    @(negedge ACLK);
    S_BVALID = 1'b0; S_BID = '0; S_BRESP = '0;
    set_br(m, 1'b0);
    #1;
    chk("busy_after_b", 64'(busy), 64'(0));
    chk("err", 64'(err), 64'(exp_err));
  endtask

  initial begin
    // reset state, checked while ARESETn is still low
    ARESETn = 0;
    do_reset();
    ARESETn = 0;
    M0_AWVALID = 1; M1_AWVALID = 1; M0_WVALID = 1; S_WREADY = 1; S_AWREADY = 1;
    @(negedge ACLK); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_awready", 64'({M0_AWREADY, M1_AWREADY, S_AWVALID}), 64'(0));
    chk("rst_wready", 64'({M0_WREADY, M1_WREADY, S_WVALID}), 64'(0));
    chk("rst_payload", 64'(S_AWINFO), 64'(0));

    // single master, 4 beats
    do_reset();
    run_txn(0, 4'h2, 32'h100, 4'd3, 4, 32'hA0, 4'h2, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);

    // contention from reset: M0, M1, M0
    do_reset();
    set_aw(0, 1'b1, mkinfo(4'h1, 32'h200, 4'd0));
    set_aw(1, 1'b1, mkinfo(4'h7, 32'h300, 4'd0));
    run_txn(0, 4'h1, 32'h200, 4'd0, 1, 32'hB0, 4'h1, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    run_txn(1, 4'h7, 32'h300, 4'd0, 1, 32'hC0, 4'h7, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00);
    run_txn(0, 4'h1, 32'h200, 4'd0, 1, 32'hB1, 4'h1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    set_aw(1, 1'b0, '0);

    // 16-beat burst with slave W backpressure every other cycle
    do_reset();
    run_txn(0, 4'h3, 32'h1000, 4'd15, 16, 32'hD00, 4'h3, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00);

    // early WLAST: AWLEN=2, WLAST on the 2nd beat
    do_reset();
    run_txn(0, 4'h4, 32'h400, 4'd2, 2, 32'hE0, 4'h4, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01);

    // late WLAST: AWLEN=1, WLAST on the 3rd beat
    do_reset();
    chk("err_cleared_by_reset", 64'(err), 64'(0));
    run_txn(1, 4'h9, 32'h500, 4'd1, 3, 32'hF0, 4'h9, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01);

    // BID mismatch on M1
    do_reset();
    run_txn(1, 4'h5, 32'h600, 4'd0, 1, 32'h11, 4'h6, 2'b10, 1'b0, 1'b0, 1'b0, 2'b10);

    // reset in the middle of DATA after 2 of 4 beats
    do_reset();
    run_txn(1, 4'h3, 32'h700, 4'd3, 2, 32'h22, 4'h3, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
    set_w(1, 1'b1, {4'h3, 32'h24, 4'hF, 1'b0});
    S_WREADY = 1'b1;
    #1;
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_grant", 64'(grant), 64'(1));
    ARESETn = 0;
    @(negedge ACLK); #1;
    chk("mr_busy", 64'(busy), 64'(0));
    chk("mr_grant", 64'(grant), 64'(0));
    chk("mr_err", 64'(err), 64'(0));
    chk("mr_valids", 64'({S_AWVALID, S_WVALID, M0_BVALID, M1_BVALID}), 64'(0));
    chk("mr_readys", 64'({M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY, S_BREADY}), 64'(0));
    chk("mr_s_w", 64'(S_W), 64'(0));
    ARESETn = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
